// File: rtl/dff_pkg.sv
// rtl/dff_pkg.sv - shared constants and helpers for the dff_pipe register pipeline
// Parity helper is used only when DFF_PIPE_PARITY_EN is defined.
package dff_pkg;

  localparam logic DEF_RESET_BIT = 1'b0;
  localparam logic DEF_SET_BIT   = 1'b1;

  // Data is zero-extended to this width before parity; zeros do not change parity.
  localparam int PARITY_MAX_W = 256;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// rtl/dff_pipe_stage.sv - one pipeline stage: data + valid register with clear/set/enable
// Carries an extra even-parity bit when DFF_PIPE_PARITY_EN is defined.
module dff_pipe_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             valid_i,
`ifdef DFF_PIPE_PARITY_EN
  input  logic             par_i,
  output logic             par_o,
`endif
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else if (set_i) begin
      data_q  <= SET_VAL;
      valid_q <= 1'b1;
    end else if (en_i) begin
      data_q  <= d_i;
      valid_q <= valid_i;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

`ifdef DFF_PIPE_PARITY_EN
  localparam logic PAR_RESET = even_parity(PARITY_MAX_W'(RESET_VAL));
  localparam logic PAR_SET   = even_parity(PARITY_MAX_W'(SET_VAL));

  logic par_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      par_q <= PAR_RESET;
    end else if (clr_i) begin
      par_q <= PAR_RESET;
    end else if (set_i) begin
      par_q <= PAR_SET;
    end else if (en_i) begin
      par_q <= par_i;
    end
  end

  assign par_o = par_q;
`endif

endmodule

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage enabled register pipeline with valid tracking and occupancy
// Optional stored parity and sticky parity_err_o when DFF_PIPE_PARITY_EN is defined.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{DEF_SET_BIT}}
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         clr_i,
  input  logic                         set_i,
  input  logic                         en_i,
  input  logic                         valid_i,
  input  logic [WIDTH-1:0]             d_i,
  output logic [WIDTH-1:0]             q_o,
  output logic                         valid_o,
`ifdef DFF_PIPE_PARITY_EN
  output logic                         parity_err_o,
`endif
  output logic [occ_width(DEPTH)-1:0]  occ_o
);

  localparam int               OCC_W    = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
`ifdef DFF_PIPE_PARITY_EN
    logic             p_in;
`endif
    if (k == 0) begin : g_head
      assign d_in = d_i;
      assign v_in = valid_i;
`ifdef DFF_PIPE_PARITY_EN
      assign p_in = even_parity(PARITY_MAX_W'(d_i));
`endif
    end else begin : g_link
      assign d_in = data[k-1];
      assign v_in = valid[k-1];
`ifdef DFF_PIPE_PARITY_EN
      assign p_in = par[k-1];
`endif
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL),
      .SET_VAL   (SET_VAL)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_i),
      .set_i   (set_i),
      .en_i    (en_i),
      .d_i     (d_in),
      .valid_i (v_in),
`ifdef DFF_PIPE_PARITY_EN
      .par_i   (p_in),
      .par_o   (par[k]),
`endif
      .q_o     (data[k]),
      .valid_o (valid[k])
    );
  end

  assign q_o     = data[DEPTH-1];
  assign valid_o = valid[DEPTH-1];

  // Occupancy tracks the valid entering minus the valid falling off the end.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      occ_o <= '0;
    end else if (clr_i) begin
      occ_o <= '0;
    end else if (set_i) begin
      occ_o <= OCC_FULL;
    end else if (en_i) begin
      case ({valid_i, valid[DEPTH-1]})
        2'b10:   occ_o <= occ_o + OCC_W'(1);
        2'b01:   occ_o <= occ_o - OCC_W'(1);
        default: occ_o <= occ_o;
      endcase
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      parity_err_o <= 1'b0;
    end else if (clr_i) begin
      parity_err_o <= 1'b0;
    end else if (par[DEPTH-1] != ^data[DEPTH-1]) begin
      parity_err_o <= 1'b1;
    end
  end
`endif

  occ_matches_valids: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) occ_o == OCC_W'($countones(valid))
  );

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised register pipeline: DEPTH back-to-back WIDTH-bit flip-flop stages with a common advance enable.
- Per-stage valid tracking and an occupancy counter.
- Synchronous set and clear.
- Generalises the single-stage dff; used for retiming and fixed-latency delay matching on datapaths.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 3, number of stages (>=1); DEPTH=1 behaves as one enabled dff with valid
RESET_VAL, {WIDTH{1'b0}}, data value of every stage after reset or clear
SET_VAL, {WIDTH{1'b1}}, data value of every stage after set

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous, active-low reset
clr_i  in  1  synchronous clear, active-high
set_i  in  1  synchronous set, active-high
en_i  in  1  advance enable: shift pipeline one stage
valid_i  in  1  d_i carries valid data
d_i  in  WIDTH  input data
q_o  out  WIDTH  last-stage data
valid_o  out  1  last-stage valid
occ_o  out  $clog2(DEPTH+1)  number of stages holding valid=1

Behaviour:
- Reset: rst_n_i low asynchronously forces all stage data = RESET_VAL, all valids = 0, occ_o = 0. Therefore q_o = RESET_VAL and valid_o = 0. Release is synchronous to the next rising edge (no extra cycle of delay).
- Priority per rising edge: clr_i > set_i > en_i > hold.
- clr_i=1: all data = RESET_VAL, all valids = 0, occ_o = 0. d_i is ignored that cycle.
- set_i=1 (clr_i=0): all data = SET_VAL, all valids = 1, occ_o = DEPTH.
- en_i=1: stage0 <= {d_i, valid_i}; stage k <= stage k-1. The last stage's old content is discarded.
- en_i=0: all stages hold; occ_o unchanged.
- Latency: with en_i held high, d_i/valid_i at edge N appear on q_o/valid_o after edge N+DEPTH-1, i.e. DEPTH edges total.
- Data flows regardless of valid_i. Invalid stages still carry their data and are not bubble-collapsed.
- occ_o on an en_i=1 edge: occ_next = occ + valid_i - valid_last.
  - Range 0..DEPTH inclusive; no wrap.
  - occ_o is registered and must always equal the popcount of the stage valids (assertion).
- Outputs are registered; no combinational path from any input to any output.
- Reset mid-operation: contents are lost immediately; no partial state survives.
- clr_i and set_i are honoured regardless of en_i.

Optional Feature:
Macro DFF_PIPE_PARITY_EN.
- Defined:
  - Each stage stores an extra even-parity bit, computed from d_i at stage0.
  - Adds output port parity_err_o (1 bit, registered): set to 1 on the edge after the last stage's stored parity mismatches ^q_o.
  - parity_err_o is sticky until clr_i or reset.
  - set_i and clr_i load the parity matching SET_VAL / RESET_VAL.
- Undefined: no parity storage and no parity_err_o port; behaviour is otherwise identical.

Decomposition:
- Package dff_pkg holds:
  - the occupancy-width function (clog2 of DEPTH+1)
  - default RESET_VAL/SET_VAL constants
  - the parity helper function
- One sub-module, dff_pipe_stage: a single WIDTH(+parity)+valid register with load/set/clear/enable inputs.
- Top dff_pipe instantiates DEPTH of them via generate, plus the occ counter.

Test Plan:
All scenarios use WIDTH=8, DEPTH=3.
- Async reset: drive rst_n_i=0 mid-cycle with the pipe full of 8'hAA -> within 1 ns q_o=8'h00, valid_o=0, occ_o=0, with no clock edge.
- Latency: en_i=1, valid_i=1, d_i=8'hAA then 8'h55, 8'h0F -> q_o=8'hAA, valid_o=1 after the 3rd edge; occ_o reads 1,2,3 after edges 1-3.
- Stall: fill with AA,55,0F; drop en_i for 4 cycles while changing d_i -> q_o stays 8'hAA and occ_o stays 3; when en_i rises, q_o=8'h55 next edge.
- Set/clear priority:
  - set_i=1 -> q_o=8'hFF, valid_o=1, occ_o=3.
  - set_i=1 and clr_i=1 together -> q_o=8'h00, valid_o=0, occ_o=0.
- Bubbles: valid_i pattern 1,0,1 with en_i=1 -> valid_o 1,0,1 on edges 3-5; occ_o=2 after edge 3; occ_o never exceeds 3.
- Parity (DFF_PIPE_PARITY_EN defined): force the stage2 data bit 0 to flip -> parity_err_o=1 next edge, held until clr_i.
